// File: rtl/crc_pkg.sv
// Shared types and constants for the streaming CRC engine.
// Holds the FSM state encoding, common generator polynomials and a bit-reverse helper.
package crc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } crc_state_t;

    localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;
    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
    localparam logic [7:0]  CRC8_POLY        = 8'h07;

    // Reverses the low 'width' bits of value; bits above width are returned as zero.
    function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int width);
        logic [31:0] rev;
        rev = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                rev[width-1-i] = value[i];
            end
        end
        return rev;
    endfunction

endpackage

// File: rtl/crc_step.sv
// Combinational CRC advance: folds BPC data bits into a CRC_W register.
// data_bits[0] is the first bit on the wire.
module crc_step
    import crc_pkg::*;
#(
    parameter int               CRC_W   = 32,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC32_POLY),
    parameter bit               REFLECT = 1'b1,
    parameter int               BPC     = 1
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic [BPC-1:0]   data_bits,
    output logic [CRC_W-1:0] crc_out
);

    localparam logic [CRC_W-1:0] POLY_REV = CRC_W'(bit_reverse(32'(POLY), CRC_W));

    always_comb begin
        logic [CRC_W-1:0] crc_v;
        logic             fb;
        crc_v = crc_in;
        fb    = 1'b0;
        for (int i = 0; i < BPC; i++) begin
            if (REFLECT) begin
                fb    = crc_v[0] ^ data_bits[i];
                crc_v = (crc_v >> 1) ^ (fb ? POLY_REV : '0);
            end else begin
                fb    = crc_v[CRC_W-1] ^ data_bits[i];
                crc_v = (crc_v << 1) ^ (fb ? POLY : '0);
            end
        end
        crc_out = crc_v;
    end

endmodule

// File: rtl/crc_engine.sv
// Parametrised streaming CRC engine: accepts byte-enabled words over valid/ready
// and folds them into a running CRC at BPC bits per clock.
module crc_engine
    import crc_pkg::*;
#(
    parameter int               CRC_W   = 32,
    parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC32_POLY),
    parameter logic [CRC_W-1:0] INIT    = '1,
    parameter logic [CRC_W-1:0] XOR_OUT = '1,
    parameter bit               REFLECT = 1'b1,
    parameter int               DATA_W  = 32,
    parameter int               BPC     = 1
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [DATA_W/8-1:0] in_keep,
    output logic                busy,
    output logic                done,
    output logic [CRC_W-1:0]    result
);

    localparam int LANES        = DATA_W / 8;
    localparam int CNT_W        = $clog2(DATA_W / BPC + 1);
    localparam int CYC_PER_BYTE = 8 / BPC;

    crc_state_t         state_reg;
    logic [CRC_W-1:0]   crc_reg;
    logic [CRC_W-1:0]   crc_next;
    logic [DATA_W-1:0]  shift_reg;
    logic [DATA_W-1:0]  wire_data;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W-1:0]   cycles_reg;
    logic [CNT_W-1:0]   word_cycles;

    // Re-order each lane into wire order so the shifter always consumes from bit 0.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        for (genvar gj = 0; gj < 8; gj++) begin : g_bit
            if (REFLECT) begin : g_lsb_first
                assign wire_data[8*gi+gj] = in_data[8*gi+gj];
            end else begin : g_msb_first
                assign wire_data[8*gi+gj] = in_data[8*gi+7-gj];
            end
        end
    end

    // Enabled lanes are contiguous from lane 0, so a popcount gives the word length.
    always_comb begin
        int lanes_on;
        lanes_on = 0;
        for (int i = 0; i < LANES; i++) begin
            lanes_on = lanes_on + (in_keep[i] ? 1 : 0);
        end
        word_cycles = CNT_W'(lanes_on * CYC_PER_BYTE);
    end

    assign cnt_next = cnt_reg + CNT_W'(1);

    crc_step #(
        .CRC_W   (CRC_W),
        .POLY    (POLY),
        .REFLECT (REFLECT),
        .BPC     (BPC)
    ) u_step (
        .crc_in    (crc_reg),
        .data_bits (shift_reg[BPC-1:0]),
        .crc_out   (crc_next)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg  <= IDLE;
            crc_reg    <= INIT;
            shift_reg  <= '0;
            cnt_reg    <= '0;
            cycles_reg <= '0;
        end else if (clear) begin
            state_reg  <= IDLE;
            crc_reg    <= INIT;
            shift_reg  <= '0;
            cnt_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg  <= wire_data;
                        cycles_reg <= word_cycles;
                        cnt_reg    <= '0;
                        state_reg  <= BUSY;
                    end
                end
                BUSY: begin
                    crc_reg   <= crc_next;
                    shift_reg <= shift_reg >> BPC;
                    cnt_reg   <= cnt_next;
                    if (cnt_next == cycles_reg) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy     = (state_reg == BUSY);
    assign in_ready = (state_reg == IDLE) && !clear;
    assign done     = (!busy && !in_valid) || clear;
    assign result   = crc_reg ^ XOR_OUT;

endmodule

// File: tb/tb_crc_engine.sv
// Directed bench for crc_engine: check strings, BPC sweep, MPEG-2 and CCITT variants,
// clear and reset behaviour, and a stalled random stream against a bytewise reference.
module tb_crc_engine;

    localparam int NDUT = 6;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        clear_a    [NDUT];
    logic        in_valid_a [NDUT];
    logic [31:0] in_data_a  [NDUT];
    logic [3:0]  in_keep_a  [NDUT];
    logic        in_ready_a [NDUT];
    logic        busy_a     [NDUT];
    logic        done_a     [NDUT];
    logic [31:0] result_m   [5];
    logic [15:0] result_ccitt;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    // CRC-32 reflected engines at BPC = 1, 2, 4, 8 (instances 0..3).
    for (genvar gi = 0; gi < 4; gi++) begin : g_crc32
        crc_engine #(.BPC(1 << gi)) u_dut (
            .CLK      (CLK),
            .nRST     (nRST),
            .clear    (clear_a[gi]),
            .in_valid (in_valid_a[gi]),
            .in_ready (in_ready_a[gi]),
            .in_data  (in_data_a[gi]),
            .in_keep  (in_keep_a[gi]),
            .busy     (busy_a[gi]),
            .done     (done_a[gi]),
            .result   (result_m[gi])
        );
    end

    crc_engine #(.REFLECT(1'b0), .XOR_OUT(32'h0), .BPC(4)) u_mpeg (
        .CLK      (CLK),
        .nRST     (nRST),
        .clear    (clear_a[4]),
        .in_valid (in_valid_a[4]),
        .in_ready (in_ready_a[4]),
        .in_data  (in_data_a[4]),
        .in_keep  (in_keep_a[4]),
        .busy     (busy_a[4]),
        .done     (done_a[4]),
        .result   (result_m[4])
    );

    crc_engine #(
        .CRC_W   (16),
        .POLY    (crc_pkg::CRC16_CCITT_POLY),
        .INIT    (16'hFFFF),
        .XOR_OUT (16'h0000),
        .REFLECT (1'b0),
        .DATA_W  (8),
        .BPC     (2)
    ) u_ccitt (
        .CLK      (CLK),
        .nRST     (nRST),
        .clear    (clear_a[5]),
        .in_valid (in_valid_a[5]),
        .in_ready (in_ready_a[5]),
        .in_data  (in_data_a[5][7:0]),
        .in_keep  (in_keep_a[5][0:0]),
        .busy     (busy_a[5]),
        .done     (done_a[5]),
        .result   (result_ccitt)
    );

    // in_keep must be non-zero and contiguous from lane 0 whenever a word is offered.
    always @(posedge CLK) begin
        for (int i = 0; i < NDUT; i++) begin
            if (nRST && in_valid_a[i]) begin
                assert (in_keep_a[i] != 4'b0 && ((in_keep_a[i] & (in_keep_a[i] + 4'd1)) == 4'b0))
                else $error("illegal in_keep on dut %0d: %b", i, in_keep_a[i]);
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] get_result(input int idx);
        if (idx == 5) return {16'h0, result_ccitt};
        else return result_m[idx];
    endfunction

    // Bytewise table-free CRC-32 (reflected) over the enabled lanes.
    function automatic logic [31:0] ref_crc32(input logic [31:0] crc_in, input logic [31:0] data,
                                              input logic [3:0] keep);
        logic [31:0] c;
        c = crc_in;
        for (int b = 0; b < 4; b++) begin
            if (keep[b]) begin
                c = c ^ {24'h0, data[8*b +: 8]};
                for (int k = 0; k < 8; k++) begin
                    c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
                end
            end
        end
        return c;
    endfunction

    task automatic send_word(input int idx, input logic [31:0] data, input logic [3:0] keep,
                             output int cycles);
        int wait_cnt;
        cycles   = 0;
        wait_cnt = 0;
        @(negedge CLK);
        in_valid_a[idx] = 1'b1;
        in_data_a[idx]  = data;
        in_keep_a[idx]  = keep;
        while (!in_ready_a[idx] && wait_cnt < 200) begin
            @(negedge CLK);
            wait_cnt++;
        end
        if (wait_cnt >= 200) check_val("ready_timeout", 32'd0, 32'd1);
        @(posedge CLK);
        #1;
        in_valid_a[idx] = 1'b0;
        while (busy_a[idx] && cycles < 100) begin
            cycles++;
            @(posedge CLK);
            #1;
        end
        $display("word dut%0d data %08h keep %b busy_cycles %0d result %08h",
                 idx, data, keep, cycles, get_result(idx));
    endtask

    task automatic send_123456789(input int idx, input int full_cyc, input int tail_cyc);
        int cyc;
        send_word(idx, 32'h34333231, 4'b1111, cyc);
        check_val($sformatf("busy_w0_dut%0d", idx), cyc, full_cyc);
        send_word(idx, 32'h38373635, 4'b1111, cyc);
        check_val($sformatf("busy_w1_dut%0d", idx), cyc, full_cyc);
        send_word(idx, 32'h00000039, 4'b0001, cyc);
        check_val($sformatf("busy_w2_dut%0d", idx), cyc, tail_cyc);
    endtask

    task automatic random_stream(input int idx);
        logic [31:0] model;
        logic [31:0] data;
        logic [3:0]  keep;
        int gap, words, nlanes, cyc;
        @(negedge CLK);
        clear_a[idx] = 1'b1;
        @(negedge CLK);
        clear_a[idx] = 1'b0;
        model  = 32'hFFFFFFFF;
        words  = 0;
        gap    = $urandom_range(0, 3);
        data   = $urandom;
        nlanes = $urandom_range(1, 4);
        keep   = 4'((1 << nlanes) - 1);
        for (cyc = 0; cyc < 3000 && words < 8; cyc++) begin
            @(negedge CLK);
            if (gap > 0) begin
                in_valid_a[idx] = 1'b0;
                gap--;
            end else begin
                in_valid_a[idx] = 1'b1;
                in_data_a[idx]  = data;
                in_keep_a[idx]  = keep;
            end
            #1;
            if (busy_a[idx]) check_val("ready_while_busy", {31'd0, in_ready_a[idx]}, 32'd0);
            if (in_valid_a[idx] && in_ready_a[idx]) begin
                model = ref_crc32(model, data, keep);
                words++;
                $display("rand dut%0d word %0d data %08h keep %b model %08h",
                         idx, words, data, keep, ~model);
                gap    = $urandom_range(0, 3);
                data   = $urandom;
                nlanes = $urandom_range(1, 4);
                keep   = 4'((1 << nlanes) - 1);
            end
        end
        @(posedge CLK);
        #1;
        in_valid_a[idx] = 1'b0;
        for (cyc = 0; cyc < 100 && busy_a[idx]; cyc++) begin
            @(posedge CLK);
            #1;
        end
        check_val($sformatf("rand_words_dut%0d", idx), words, 32'd8);
        check_val($sformatf("rand_crc_dut%0d", idx), get_result(idx), ~model);
    endtask

    initial begin
        int cyc;
        nRST = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            clear_a[i]    = 1'b0;
            in_valid_a[i] = 1'b0;
            in_data_a[i]  = 32'h0;
            in_keep_a[i]  = 4'b0001;
        end
        repeat (3) @(posedge CLK);
        #1;
        nRST = 1'b1;
        @(negedge CLK);

        // Reset state of every engine.
        for (int i = 0; i < NDUT; i++) begin
            check_val($sformatf("rst_ready_dut%0d", i), {31'd0, in_ready_a[i]}, 32'd1);
            check_val($sformatf("rst_busy_dut%0d", i), {31'd0, busy_a[i]}, 32'd0);
            check_val($sformatf("rst_done_dut%0d", i), {31'd0, done_a[i]}, 32'd1);
        end
        for (int i = 0; i < 4; i++) check_val($sformatf("rst_result_dut%0d", i), get_result(i), 32'h0);
        check_val("rst_result_mpeg", get_result(4), 32'hFFFFFFFF);
        check_val("rst_result_ccitt", get_result(5), 32'h0000FFFF);

        // CRC-32 check string at every BPC.
        for (int i = 0; i < 4; i++) begin
            send_123456789(i, 32 >> i, 8 >> i);
            check_val($sformatf("crc32_bpc%0d", 1 << i), get_result(i), 32'hCBF43926);
        end

        send_123456789(4, 8, 2);
        check_val("crc32_mpeg2", get_result(4), 32'h0376E6E7);

        for (int k = 0; k < 9; k++) begin
            send_word(5, {24'h0, 8'h31 + 8'(k)}, 4'b0001, cyc);
            check_val($sformatf("busy_ccitt_b%0d", k), cyc, 32'd4);
        end
        check_val("crc16_ccitt", get_result(5), 32'h000029B1);

        // clear mid-word with in_valid high: word dropped, register back to INIT.
        @(negedge CLK);
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = 32'hDEADBEEF;
        in_keep_a[0]  = 4'b1111;
        #1;
        check_val("idle_valid_done", {31'd0, done_a[0]}, 32'd0);
        check_val("idle_valid_ready", {31'd0, in_ready_a[0]}, 32'd1);
        @(posedge CLK);
        #1;
        in_valid_a[0] = 1'b0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        check_val("clr_pre_busy", {31'd0, busy_a[0]}, 32'd1);
        clear_a[0]    = 1'b1;
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = 32'h12345678;
        #1;
        check_val("clr_ready", {31'd0, in_ready_a[0]}, 32'd0);
        check_val("clr_done", {31'd0, done_a[0]}, 32'd1);
        @(posedge CLK);
        #1;
        clear_a[0]    = 1'b0;
        in_valid_a[0] = 1'b0;
        check_val("clr_busy", {31'd0, busy_a[0]}, 32'd0);
        check_val("clr_init", get_result(0), 32'h0);
        @(posedge CLK);
        #1;
        check_val("clr_no_accept", {31'd0, busy_a[0]}, 32'd0);
        send_123456789(0, 32, 8);
        check_val("crc32_after_clr", get_result(0), 32'hCBF43926);

        for (int i = 0; i < 4; i++) random_stream(i);

        // Asynchronous reset in the middle of a word.
        @(negedge CLK);
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = 32'hA5A5A5A5;
        in_keep_a[0]  = 4'b1111;
        @(posedge CLK);
        #1;
        in_valid_a[0] = 1'b0;
        repeat (3) @(posedge CLK);
        #3;
        nRST = 1'b0;
        #1;
        check_val("arst_busy", {31'd0, busy_a[0]}, 32'd0);
        check_val("arst_result", get_result(0), 32'h0);
        check_val("arst_ready", {31'd0, in_ready_a[0]}, 32'd1);
        @(negedge CLK);
        nRST = 1'b1;
        repeat (2) @(posedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc_engine.md
# crc_engine

Parametrised streaming CRC engine. It generalises the team's fixed byte-serial CRC-32 unit to arbitrary CRC width and polynomial, multi-byte input words with byte-enables, selectable bits-per-cycle throughput, and reflected or non-reflected bit order. It sits beside DMA and peripheral datapaths (SPI flash, UART bootloader, packet checkers), takes data over a valid/ready handshake, and exposes a running result after every word.

## Interface
- CRC_W, 32: CRC register width, 8..32.
- POLY, 32'h04C11DB7: generator polynomial in normal (MSB-first) form, CRC_W bits.
- INIT, all ones: register value after reset or clear.
- XOR_OUT, all ones: value XORed onto the register to form result.
- REFLECT, 1: 1 = LSB-first per byte (shift right, bit-reversed POLY); 0 = MSB-first (shift left, POLY).
- DATA_W, 32: input word width, a multiple of 8 (8..64).
- BPC, 1: bits consumed per clock; one of 1, 2, 4, 8.
- CLK  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous restart: register <= INIT, in-flight word aborted.
- in_valid  in  1  input word present.
- in_ready  out  1  engine can accept a word this cycle.
- in_data  in  DATA_W  byte lane 0 = bits [7:0] = first byte on the wire.
- in_keep  in  DATA_W/8  byte enables; contiguous from lane 0, at least one set.
- busy  out  1  word in flight.
- done  out  1  idle and no word pending (~busy & ~in_valid) | clear.
- result  out  CRC_W  register ^ XOR_OUT, combinational from the register.

## Operation
- States: IDLE, BUSY. Reset enters IDLE with register = INIT and bit counter = 0.
- IDLE: in_ready = ~clear. A word transfers on in_valid & in_ready; data and keep are latched and the state moves to BUSY with counter = 0.
- The total bit count N = 8 × popcount(in_keep).
- BUSY: each cycle consumes BPC bits in wire order. Bytes are taken from lane 0 upward. Within a byte, bit 0 goes first when REFLECT = 1 and bit 7 goes first when REFLECT = 0. After N/BPC cycles the state returns to IDLE.
- Reflected step per bit b: fb = reg[0] ^ b; reg = (reg >> 1) ^ (fb ? rev(POLY) : 0).
- Normal step per bit b: fb = reg[CRC_W-1] ^ b; reg = (reg << 1) ^ (fb ? POLY : 0), truncated to CRC_W.
- Disabled lanes are never consumed.
- clear has priority over all other activity. It returns to IDLE, loads INIT, discards the latched word, and holds in_ready low during the cycle it is asserted.
- Non-contiguous or all-zero in_keep is illegal. The bench flags it with an assertion and RTL behaviour is undefined.
- Reset values: in_ready 1, busy 0, done = ~in_valid, result = INIT ^ XOR_OUT.

## Timing
- Accept at edge k: busy is high from k+1 through edge k+N/BPC. result is final after edge k+N/BPC, and in_ready is high again in that same cycle.
- No back-to-back acceptance while BUSY. Throughput is one word per N/BPC + 1 cycles.
- A full 32-bit word at BPC = 8 takes 4 busy cycles. At BPC = 1 it takes 32.
- result changes every busy cycle; it is stable only when busy is 0.
- clear during BUSY: the register shows INIT after the next edge and no further bits are consumed.
- nRST during BUSY: behaves as reset, asynchronously.
- Counter width is clog2(DATA_W/BPC + 1) and must not wrap within a word.

## Structure
- crc_pkg holds:
  - state enum {IDLE, BUSY};
  - constants CRC32_POLY 32'h04C11DB7, CRC16_CCITT_POLY 16'h1021, CRC8_POLY 8'h07;
  - a bit-reverse function.
- crc_step sub-module: combinational advance of a CRC_W register by BPC data bits, parametrised by CRC_W, POLY and REFLECT. It is instantiated once.
- Top level holds the FSM, bit counter, data shift register and handshake.

## Test plan
- Defaults, "123456789" sent as two full words plus one word with keep = 4'b0001 -> result 0xCBF43926. Repeat with BPC = 1, 2, 4, 8: result is the same and busy lasts 32/BPC cycles per full word.
- REFLECT = 0, XOR_OUT = 0, same data -> 0x0376E6E7 (CRC-32/MPEG-2).
- CRC_W = 16, POLY 16'h1021, INIT 16'hFFFF, REFLECT = 0, XOR_OUT = 0, DATA_W = 8, "123456789" -> 0x29B1.
- Reset with no data -> result 0x00000000 (INIT ^ XOR_OUT with defaults), in_ready 1, done 1.
- clear asserted mid-BUSY, with in_valid also high -> word not accepted, register = INIT next cycle. Then "123456789" -> 0xCBF43926.
- in_valid held high with random stall gaps and random BPC -> in_ready low whenever busy, no word dropped or duplicated, result matches the reference model.
